denoise_window_gen: RTL and testbench

DENOISE_WINDOW_GEN -- requirements
Module: denoise_window_gen

---
 rtl/denoise_pkg.sv | 34 +++
 rtl/denoise_window_gen_if.sv | 36 +++
 rtl/denoise_linebuf.sv | 40 ++++
 rtl/denoise_window_gen.sv | 189 ++++++++++++++++++
 tb/tb_denoise_window_gen.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/denoise_pkg.sv
// denoise_pkg -- shared constants, types and helpers for the denoise window generator.
//   PIX_W_DEF          : default pixel width
//   KROWS_MIN/KROWS_MAX: legal range of the vertical window height
//   HEAD_W             : width of ring/row indices (covers up to KROWS_MAX-1 memories)
//   pixel_t            : pixel type at the default width
//   ring_idx()         : ring slot holding the line 'back' lines before the head
package denoise_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int KROWS_MIN = 2;
    localparam int KROWS_MAX = 7;
    localparam int HEAD_W    = 3;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    // (head - back) mod depth, with head < depth and 1 <= back <= depth.
    // back == depth lands on the head slot itself, which still holds the
    // oldest line because the read happens before the write.
    function automatic logic [HEAD_W-1:0] ring_idx(
        input logic [HEAD_W-1:0] head,
        input logic [HEAD_W-1:0] back,
        input logic [HEAD_W-1:0] depth
    );
        logic [HEAD_W:0] sum_v;
        sum_v = {1'b0, head} + {1'b0, depth} - {1'b0, back};
        if (sum_v >= {1'b0, depth}) begin
            sum_v = sum_v - {1'b0, depth};
        end else begin
            sum_v = sum_v;
        end
        return sum_v[HEAD_W-1:0];
    endfunction

endpackage

// File: rtl/denoise_window_gen_if.sv
// denoise_window_gen_if -- pixel stream in, vertical column out.
//   frame_begin, line_begin : one-cycle framing pulses
//   in_valid, in_pix        : incoming pixel
//   out_valid, out_col      : vertical column (slice 0 = current row)
//   out_rows_ok, out_x      : all slices real / column index of out_col
//   overflow                : sticky line-too-long flag
// Modports: master = pixel source, slave = window generator.
interface denoise_window_gen_if
    import denoise_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int KROWS    = 3,
    parameter int LINE_MAX = 1024
) ();
    localparam int ADDR_W = $clog2(LINE_MAX);

    logic                    frame_begin;
    logic                    line_begin;
    logic                    in_valid;
    logic [PIX_W-1:0]        in_pix;
    logic                    out_valid;
    logic [KROWS*PIX_W-1:0]  out_col;
    logic                    out_rows_ok;
    logic [ADDR_W-1:0]       out_x;
    logic                    overflow;

    modport master (
        output frame_begin, line_begin, in_valid, in_pix,
        input  out_valid, out_col, out_rows_ok, out_x, overflow
    );

    modport slave (
        input  frame_begin, line_begin, in_valid, in_pix,
        output out_valid, out_col, out_rows_ok, out_x, overflow
    );
endinterface

// File: rtl/denoise_linebuf.sv
// denoise_linebuf -- one simple dual-port line memory with a registered read.
//   clk, rst_n         : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr      : read request, rd_data valid the following cycle
// A read and write to the same address in one cycle returns the old contents.
module denoise_linebuf #(
    parameter int PIX_W  = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);
    logic [PIX_W-1:0] mem_r [DEPTH];
    logic [PIX_W-1:0] rd_data_r;

    // Memory write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, sees pre-write contents on an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {PIX_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;
endmodule

// File: rtl/denoise_window_gen.sv
// denoise_window_gen -- builds a KROWS-high vertical pixel column from a raster
// stream using KROWS-1 line memories arranged as a ring (rotating head pointer).
//   pixclk, reset_n : clock, async active-low reset
//   bus (slave)     : frame_begin, line_begin, in_valid, in_pix in;
//                     out_valid, out_col, out_rows_ok, out_x, overflow out
// Output is one cycle after each accepted pixel. Rows not yet filled in the
// current frame are padded with zero, or, when DENOISE_BORDER_REPLICATE_EN is
// defined, with a copy of the oldest real row.
module denoise_window_gen
    import denoise_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int KROWS    = 3,
    parameter int LINE_MAX = 1024
) (
    input  logic                 pixclk,
    input  logic                 reset_n,
    denoise_window_gen_if.slave  bus
);
    localparam int ADDR_W = $clog2(LINE_MAX);
    localparam int X_W    = ADDR_W + 1;
    localparam int NMEM   = KROWS - 1;
    localparam int NSLOT  = 2 ** HEAD_W;

    localparam logic [HEAD_W-1:0] ROW_MAX   = HEAD_W'(KROWS - 1);
    localparam logic [HEAD_W-1:0] HEAD_LAST = HEAD_W'(KROWS - 2);
    localparam logic [HEAD_W-1:0] DEPTH     = HEAD_W'(NMEM);
    localparam logic [X_W-1:0]    X_LIMIT   = X_W'(LINE_MAX);

    // Line position state and its values after this cycle's framing pulses
    logic [X_W-1:0]    x_r, x_s;
    logic [HEAD_W-1:0] head_r, head_s;
    logic [HEAD_W-1:0] row_r, row_s;
    logic              first_r, first_s;
    logic              accept_s, drop_s;

    // Output stage
    logic              out_valid_r;
    logic [ADDR_W-1:0] out_x_r;
    logic              rows_ok_r;
    logic              overflow_r;
    logic [PIX_W-1:0]  pix_r;
    logic [HEAD_W-1:0] sel_head_r;
    logic [HEAD_W-1:0] sel_row_r;
    logic [KROWS*PIX_W-1:0] col_s;

    // One entry per possible ring slot so the head-based index never overruns
    logic [PIX_W-1:0]  rd_data_s [NSLOT];

    // Apply frame_begin first, then line_begin, so a pixel arriving with them
    // already belongs to the new line
    always_comb begin
        x_s     = x_r;
        head_s  = head_r;
        row_s   = row_r;
        first_s = first_r;
        if (bus.frame_begin) begin
            x_s     = {X_W{1'b0}};
            head_s  = {HEAD_W{1'b0}};
            row_s   = {HEAD_W{1'b0}};
            first_s = 1'b1;
        end else begin
            first_s = first_r;
        end
        if (bus.line_begin) begin
            x_s = {X_W{1'b0}};
            if (first_s) begin
                // first line of the frame: nothing older to rotate past
                first_s = 1'b0;
            end else begin
                if (row_s != ROW_MAX) begin
                    row_s = row_s + 3'd1;
                end else begin
                    row_s = row_s;
                end
                if (head_s == HEAD_LAST) begin
                    head_s = {HEAD_W{1'b0}};
                end else begin
                    head_s = head_s + 3'd1;
                end
            end
        end else begin
            x_s = x_s;
        end
    end

    assign accept_s = bus.in_valid && (x_s != X_LIMIT);
    assign drop_s   = bus.in_valid && (x_s == X_LIMIT);

    // Line position registers
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            x_r     <= {X_W{1'b0}};
            head_r  <= {HEAD_W{1'b0}};
            row_r   <= {HEAD_W{1'b0}};
            first_r <= 1'b1;
        end else begin
            x_r     <= accept_s ? (x_s + X_W'(1)) : x_s;
            head_r  <= head_s;
            row_r   <= row_s;
            first_r <= first_s;
        end
    end

    // Line memory ring: all memories read at x, the head memory written at x
    genvar j;
    generate
        for (j = 0; j < NSLOT; j++) begin : g_slot
            if (j < NMEM) begin : g_mem
                denoise_linebuf #(
                    .PIX_W (PIX_W),
                    .DEPTH (LINE_MAX),
                    .ADDR_W(ADDR_W)
                ) u_linebuf (
                    .clk    (pixclk),
                    .rst_n  (reset_n),
                    .wr_en  (accept_s && (head_s == HEAD_W'(j))),
                    .wr_addr(x_s[ADDR_W-1:0]),
                    .wr_data(bus.in_pix),
                    .rd_en  (accept_s),
                    .rd_addr(x_s[ADDR_W-1:0]),
                    .rd_data(rd_data_s[j])
                );
            end else begin : g_none
                assign rd_data_s[j] = {PIX_W{1'b0}};
            end
        end
    endgenerate

    // Output stage aligned with the registered memory read
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_x_r     <= {ADDR_W{1'b0}};
            rows_ok_r   <= 1'b0;
            overflow_r  <= 1'b0;
            pix_r       <= {PIX_W{1'b0}};
            sel_head_r  <= {HEAD_W{1'b0}};
            sel_row_r   <= {HEAD_W{1'b0}};
        end else begin
            out_valid_r <= accept_s;
            overflow_r  <= overflow_r | drop_s;
            if (accept_s) begin
                out_x_r    <= x_s[ADDR_W-1:0];
                rows_ok_r  <= (row_s == ROW_MAX);
                pix_r      <= bus.in_pix;
                sel_head_r <= head_s;
                sel_row_r  <= row_s;
            end
        end
    end

`ifdef DENOISE_BORDER_REPLICATE_EN
    logic [PIX_W-1:0] oldest_s;

    // Oldest real row of the window; row 0 alone means the current pixel
    always_comb begin
        oldest_s = pix_r;
        if (sel_row_r == {HEAD_W{1'b0}}) begin
            oldest_s = pix_r;
        end else begin
            oldest_s = rd_data_s[ring_idx(sel_head_r, sel_row_r, DEPTH)];
        end
    end
`endif

    // Column assembly: slice k comes from the line k rows back, padded if unfilled
    always_comb begin
        col_s = {(KROWS*PIX_W){1'b0}};
        col_s[PIX_W-1:0] = pix_r;
        for (int k = 1; k < KROWS; k++) begin
            if (HEAD_W'(k) <= sel_row_r) begin
                col_s[k*PIX_W +: PIX_W] = rd_data_s[ring_idx(sel_head_r, HEAD_W'(k), DEPTH)];
            end else begin
`ifdef DENOISE_BORDER_REPLICATE_EN
                col_s[k*PIX_W +: PIX_W] = oldest_s;
`else
                col_s[k*PIX_W +: PIX_W] = {PIX_W{1'b0}};
`endif
            end
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_col     = col_s;
    assign bus.out_rows_ok = rows_ok_r;
    assign bus.out_x       = out_x_r;
    assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_denoise_window_gen.sv
// tb_denoise_window_gen -- directed, table-driven bench for denoise_window_gen
// with KROWS=3, LINE_MAX=8. Padding expectations follow DENOISE_BORDER_REPLICATE_EN.
module tb_denoise_window_gen;
    import denoise_pkg::*;

    localparam int PW = 8;
    localparam int KR = 3;
    localparam int LM = 8;
`ifdef DENOISE_BORDER_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic pixclk = 1'b0;
    logic reset_n;
    always #5 pixclk = ~pixclk;

    denoise_window_gen_if #(.PIX_W(PW), .KROWS(KR), .LINE_MAX(LM)) bus ();

    denoise_window_gen #(.PIX_W(PW), .KROWS(KR), .LINE_MAX(LM)) dut (
        .pixclk (pixclk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int          line;
        int          x;
        logic [23:0] col;
        logic        ok;
    } vec_t;

    vec_t        vecs [7];
    logic [23:0] cap_col [5][8];
    logic        cap_ok  [5][8];
    logic [2:0]  cap_x   [5][8];
    logic        cap_v   [5][8];
    int errors = 0;
    int checks = 0;

    function automatic logic [23:0] mk(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
        return {s2, s1, s0};
    endfunction

    function automatic logic [7:0] pad(input logic [7:0] oldest);
        return REP ? oldest : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs; on return the outputs for that cycle are visible
    task automatic drive(input logic fb, input logic lb, input logic v, input pixel_t p);
        bus.frame_begin = fb;
        bus.line_begin  = lb;
        bus.in_valid    = v;
        bus.in_pix      = p;
        @(negedge pixclk);
        bus.frame_begin = 1'b0;
        bus.line_begin  = 1'b0;
        bus.in_valid    = 1'b0;
    endtask

    task automatic send_line(input int line, input int npix, input bit rec);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("lb_no_out", 32'(bus.out_valid), 32'd0);
        for (int x = 0; x < npix; x++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(16 * line + x));
            if (rec) begin
                cap_col[line][x] = bus.out_col;
                cap_ok[line][x]  = bus.out_rows_ok;
                cap_x[line][x]   = bus.out_x;
                cap_v[line][x]   = bus.out_valid;
            end
        end
    endtask

    initial begin
        vecs[0] = '{0, 3, mk(8'h03, pad(8'h03), pad(8'h03)), 1'b0};
        vecs[1] = '{1, 2, mk(8'h12, 8'h02, pad(8'h02)), 1'b0};
        vecs[2] = '{2, 1, mk(8'h21, 8'h11, 8'h01), 1'b1};
        vecs[3] = '{2, 3, mk(8'h23, 8'h13, 8'h03), 1'b1};
        vecs[4] = '{3, 0, mk(8'h30, 8'h20, 8'h10), 1'b1};
        vecs[5] = '{4, 3, mk(8'h43, 8'h33, 8'h23), 1'b1};
        vecs[6] = '{4, 0, mk(8'h40, 8'h30, 8'h20), 1'b1};

        reset_n         = 1'b0;
        bus.frame_begin = 1'b0;
        bus.line_begin  = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_pix      = 8'h00;
        repeat (2) @(negedge pixclk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_col", 32'(bus.out_col), 32'd0);
        check("rst_x", 32'(bus.out_x), 32'd0);
        check("rst_ok", 32'(bus.out_rows_ok), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        reset_n = 1'b1;
        @(negedge pixclk);

        // Five 4-pixel lines: ring wraps twice
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int l = 0; l < 5; l++) begin
            send_line(l, 4, 1'b1);
        end
        for (int i = 0; i < 7; i++) begin
            check($sformatf("col_L%0d_x%0d", vecs[i].line, vecs[i].x),
                  32'(cap_col[vecs[i].line][vecs[i].x]), 32'(vecs[i].col));
            check($sformatf("ok_L%0d_x%0d", vecs[i].line, vecs[i].x),
                  32'(cap_ok[vecs[i].line][vecs[i].x]), 32'(vecs[i].ok));
            check($sformatf("x_L%0d_x%0d", vecs[i].line, vecs[i].x),
                  32'(cap_x[vecs[i].line][vecs[i].x]), 32'(vecs[i].x));
            check($sformatf("v_L%0d_x%0d", vecs[i].line, vecs[i].x),
                  32'(cap_v[vecs[i].line][vecs[i].x]), 32'd1);
        end

        // frame_begin + line_begin + pixel together: column 0 of line 0
        drive(1'b1, 1'b1, 1'b1, 8'hA0);
        check("fblb_valid", 32'(bus.out_valid), 32'd1);
        check("fblb_x", 32'(bus.out_x), 32'd0);
        check("fblb_col", 32'(bus.out_col), 32'(mk(8'hA0, pad(8'hA0), pad(8'hA0))));
        check("fblb_ok", 32'(bus.out_rows_ok), 32'd0);
        // line_begin with pixel: column 0 of line 1
        drive(1'b0, 1'b1, 1'b1, 8'hB0);
        check("lbpix_x", 32'(bus.out_x), 32'd0);
        check("lbpix_col", 32'(bus.out_col), 32'(mk(8'hB0, 8'hA0, pad(8'hA0))));
        drive(1'b0, 1'b0, 1'b1, 8'hB1);
        check("lbpix_x1", 32'(bus.out_x), 32'd1);

        // Overflow: ninth pixel dropped, flag sticky across frames
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        for (int x = 0; x < 8; x++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(x));
        end
        check("ovf_8th_x", 32'(bus.out_x), 32'd7);
        check("ovf_8th_flag", 32'(bus.overflow), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 8'h08);
        check("ovf_9th_valid", 32'(bus.out_valid), 32'd0);
        check("ovf_9th_flag", 32'(bus.overflow), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 8'h55);
        check("ovf_next_valid", 32'(bus.out_valid), 32'd1);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset in the middle of line 1, then a fresh frame
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_line(0, 4, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h60);
        drive(1'b0, 1'b0, 1'b1, 8'h61);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_col", 32'(bus.out_col), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge pixclk);
        reset_n = 1'b1;
        @(negedge pixclk);
        drive(1'b1, 1'b1, 1'b1, 8'h70);
        check("post_rst_col0", 32'(bus.out_col), 32'(mk(8'h70, pad(8'h70), pad(8'h70))));
        check("post_rst_ok0", 32'(bus.out_rows_ok), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 8'h71);
        check("post_rst_col1", 32'(bus.out_col), 32'(mk(8'h71, pad(8'h71), pad(8'h71))));
        check("post_rst_x1", 32'(bus.out_x), 32'd1);
        check("post_rst_ok1", 32'(bus.out_rows_ok), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
